// File: rtl/pipelined_compare_tracker.sv
// pipelined_compare_tracker
//
// Streaming magnitude comparator. Accepts (a, b) operand pairs over a
// valid/ready handshake and registers one-hot Equal/Greater/Less flags one
// cycle after acceptance. Each pair carries its own is_signed mode bit.
// Alongside the flags the block keeps running statistics over every
// accepted sample: the largest and smallest a seen, and saturating counters
// of each outcome. A synchronous clr wipes the statistics without
// disturbing the result register or the handshake.
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   in_valid, in_ready  input handshake; in_ready = !out_valid || out_ready
//   a, b, is_signed     operand pair and its compare mode
//   clr                 synchronous clear of counters and min/max
//   out_valid, out_ready  output handshake for the single result register
//   Equal, Greater, Less  registered one-hot compare result
//   run_max, run_min    running extremes of accepted a values
//   stats_valid         at least one sample recorded since reset/clr
//   eq_count, gt_count, lt_count  saturating outcome counters
module pipelined_compare_tracker #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             Equal,
    output logic             Greater,
    output logic             Less,
    output logic [WIDTH-1:0] run_max,
    output logic [WIDTH-1:0] run_min,
    output logic             stats_valid,
    output logic [CNT_W-1:0] eq_count,
    output logic [CNT_W-1:0] gt_count,
    output logic [CNT_W-1:0] lt_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             accept;
    logic             a_eq_b;
    logic             a_gt_b;
    logic             a_lt_b;
    logic             a_gt_max;
    logic             a_lt_min;
    logic             stats_live;
    logic [CNT_W-1:0] eq_next;
    logic [CNT_W-1:0] gt_next;
    logic [CNT_W-1:0] lt_next;

    // x > y under the given mode; signed mode reinterprets both as
    // two's-complement.
    function automatic logic greater_than(input logic [WIDTH-1:0] x,
                                          input logic [WIDTH-1:0] y,
                                          input logic             sgn);
        if (sgn)
            return $signed(x) > $signed(y);
        else
            return x > y;
    endfunction

    // Saturating increment on top of a base that is already cleared when
    // clr is high, so a clear coincident with an accept records the sample
    // into a freshly zeroed counter.
    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] cnt,
                                              input logic             hit,
                                              input logic             clear);
        logic [CNT_W-1:0] base;
        base = clear ? '0 : cnt;
        if (hit && base != CNT_MAX)
            return base + 1'b1;
        else
            return base;
    endfunction

    // Only one result register: a new pair can enter when it is empty or
    // is being drained this cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        a_eq_b   = (a == b);
        a_gt_b   = greater_than(a, b, is_signed);
        a_lt_b   = !a_eq_b && !a_gt_b;
        a_gt_max = greater_than(a, run_max, is_signed);
        a_lt_min = greater_than(run_min, a, is_signed);
        // Statistics are treated as empty when a clear lands this cycle.
        stats_live = stats_valid && !clr;
        eq_next  = bump(eq_count, accept && a_eq_b, clr);
        gt_next  = bump(gt_count, accept && a_gt_b, clr);
        lt_next  = bump(lt_count, accept && a_lt_b, clr);
    end

    // Result register: loads on accept, empties on a consume with no new
    // accept, and otherwise holds so flags stay stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            Equal     <= 1'b0;
            Greater   <= 1'b0;
            Less      <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            Equal     <= a_eq_b;
            Greater   <= a_gt_b;
            Less      <= a_lt_b;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Running min/max. The first sample after reset or clear seeds both
    // extremes; later samples compare in their own mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_max     <= '0;
            run_min     <= '0;
            stats_valid <= 1'b0;
        end else if (accept) begin
            stats_valid <= 1'b1;
            if (!stats_live) begin
                run_max <= a;
                run_min <= a;
            end else begin
                if (a_gt_max)
                    run_max <= a;
                if (a_lt_min)
                    run_min <= a;
            end
        end else if (clr) begin
            run_max     <= '0;
            run_min     <= '0;
            stats_valid <= 1'b0;
        end
    end

    // Outcome counters update in the same cycle the flags load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eq_count <= '0;
            gt_count <= '0;
            lt_count <= '0;
        end else begin
            eq_count <= eq_next;
            gt_count <= gt_next;
            lt_count <= lt_next;
        end
    end

endmodule
